// File: rtl/shift_register_pkg.sv
// -----------------------------------------------------------------------------
// shift_register_pkg
// Shared definitions for the universal shift register and its barrel shifter:
// the operation codes driven on the 3-bit op input, and a helper that derives
// the shift-amount width from the data width.
// -----------------------------------------------------------------------------
package shift_register_pkg;

    localparam logic [2:0] HOLD = 3'd0;
    localparam logic [2:0] LOAD = 3'd1;
    localparam logic [2:0] SHL  = 3'd2;
    localparam logic [2:0] SHR  = 3'd3;
    localparam logic [2:0] ASR  = 3'd4;
    localparam logic [2:0] ROL  = 3'd5;
    localparam logic [2:0] ROR  = 3'd6;
    localparam logic [2:0] CLR  = 3'd7;

    // Width of the shift-amount input for a given data width. A 1-bit floor
    // keeps the port legal even for degenerate widths.
    function automatic int calc_aw(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/shift_register_univ_barrel_shift.sv
// -----------------------------------------------------------------------------
// barrel_shift
// Purely combinational WIDTH-bit shifter/rotator used by shift_register_univ.
//
// Ports:
//   value   - operand to be shifted or rotated
//   amt     - shift/rotate amount (may exceed WIDTH-1 for non power-of-2 widths)
//   op      - operation code (SHL, SHR, ASR, ROL, ROR; others pass value through)
//   fill    - serial fill bit for SHL/SHR
//   result  - shifted/rotated value
//   out_bit - last bit shifted or rotated out (carry candidate)
// -----------------------------------------------------------------------------
module barrel_shift
    import shift_register_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AW    = calc_aw(WIDTH)
) (
    input  logic [WIDTH-1:0] value,
    input  logic [AW-1:0]    amt,
    input  logic [2:0]       op,
    input  logic             fill,
    output logic [WIDTH-1:0] result,
    output logic             out_bit
);

    logic          over;
    logic [AW-1:0] rot_amt;
    logic          fill_bit;

    // Shifts are done by placing the operand next to a block of fill bits in a
    // double-width word and shifting that, so vacated positions pick up the
    // fill automatically. Amounts at or beyond WIDTH saturate to all-fill for
    // shifts; rotates wrap. Since amt < 2*WIDTH, one subtraction is enough for
    // the modulo.
    always_comb begin
        over     = ({1'b0, amt} >= (AW+1)'(WIDTH));
        rot_amt  = over ? (amt - AW'(WIDTH)) : amt;
        fill_bit = (op == ASR) ? value[WIDTH-1] : fill;
        result   = value;
        out_bit  = 1'b0;

        case (op)
            SHL: begin
                if (over) begin
                    result  = {WIDTH{fill_bit}};
                    out_bit = fill_bit;
                end else begin
                    result  = WIDTH'(({value, {WIDTH{fill_bit}}} << amt) >> WIDTH);
                    out_bit = 1'(({1'b0, value} << amt) >> WIDTH);
                end
            end
            SHR, ASR: begin
                if (over) begin
                    result  = {WIDTH{fill_bit}};
                    out_bit = fill_bit;
                end else begin
                    result  = WIDTH'({{WIDTH{fill_bit}}, value} >> amt);
                    out_bit = 1'({value, 1'b0} >> amt);
                end
            end
            ROL: begin
                result  = WIDTH'(({value, value} << rot_amt) >> WIDTH);
                out_bit = result[0];
            end
            ROR: begin
                result  = WIDTH'({value, value} >> rot_amt);
                out_bit = result[WIDTH-1];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/shift_register_univ.sv
// -----------------------------------------------------------------------------
// shift_register_univ
// Parametrised universal register: hold, parallel load, clear, logical and
// arithmetic shifts and rotates by a variable amount, with a registered
// carry-out and a registered zero flag.
//
// Ports:
//   clk    - rising-edge clock
//   reset  - asynchronous active-low reset (0 = in reset)
//   en     - operation enable; 0 holds every register
//   op     - operation select (see shift_register_pkg)
//   d      - parallel load data
//   amt    - shift/rotate amount
//   sin    - serial fill bit for SHL/SHR
//   q      - registered value
//   carry  - last bit shifted or rotated out
//   zero   - 1 when q == 0
// -----------------------------------------------------------------------------
module shift_register_univ
    import shift_register_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int               AW        = calc_aw(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] d,
    input  logic [AW-1:0]    amt,
    input  logic             sin,
    output logic [WIDTH-1:0] q,
    output logic             carry,
    output logic             zero
);

    logic [WIDTH-1:0] shift_result;
    logic             shift_out;
    logic [WIDTH-1:0] q_next;
    logic             carry_next;
    logic             zero_next;

    barrel_shift #(
        .WIDTH (WIDTH),
        .AW    (AW)
    ) u_shift (
        .value   (q),
        .amt     (amt),
        .op      (op),
        .fill    (sin),
        .result  (shift_result),
        .out_bit (shift_out)
    );

    // Op decode. A zero amount leaves q and carry alone for every shift and
    // rotate, but zero is still refreshed from the (unchanged) next value.
    always_comb begin
        q_next     = q;
        carry_next = carry;
        zero_next  = zero;
        if (en) begin
            case (op)
                LOAD: q_next = d;
                CLR: begin
                    q_next     = '0;
                    carry_next = 1'b0;
                end
                SHL, SHR, ASR, ROL, ROR: begin
                    if (amt != '0) begin
                        q_next     = shift_result;
                        carry_next = shift_out;
                    end
                end
                default: ;
            endcase
            zero_next = (q_next == '0);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q     <= RESET_VAL;
            carry <= 1'b0;
            zero  <= (RESET_VAL == '0);
        end else begin
            q     <= q_next;
            carry <= carry_next;
            zero  <= zero_next;
        end
    end

endmodule
